lfsr_stream: RTL and testbench

- Parametrised Fibonacci LFSR pseudo-random bit generator. Width, tap polynomial and reset seed are set by parameters.
- Packs generated bits into OUT_BITS-wide words and delivers them over a valid/ready handshake.
- Supports runtime seed load with a zero-seed guard.
- Used as the stimulus/scrambler source in test and BIST paths; drop-in for the fixed 32-bit serial generator when the default parameters are used.

---
 rtl/lfsr_stream.sv | 134 +++++++++++++
 tb/tb_lfsr_stream.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR bit generator packing MSB-first words onto a valid/ready stream; stalls losslessly under backpressure.
// Define LFSR_PERIOD_CNT_EN to build the step counter and return-to-start detector (period_count/period_hit).
module lfsr_stream #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(32'h8020_0003),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(32'h0000_0001),
  parameter int               OUT_BITS   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                load_seed,
  input  logic [WIDTH-1:0]    seed,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                seed_err,
  output logic [WIDTH-1:0]    lfsr_state,
  output logic [WIDTH-1:0]    period_count,
  output logic                period_hit
);

  localparam int CW = $clog2(OUT_BITS + 1);

  if (WIDTH < 3) begin : g_bad_width
    $error("lfsr_stream: WIDTH must be at least 3");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_stream: TAPS[WIDTH-1] must be set");
  end
  if (RESET_SEED == '0) begin : g_bad_seed
    $error("lfsr_stream: RESET_SEED must be nonzero");
  end
  if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
    $error("lfsr_stream: OUT_BITS must lie in 1..WIDTH");
  end

  logic [WIDTH-1:0]    state;
  logic [WIDTH-1:0]    state_nxt;
  logic [WIDTH-1:0]    seed_eff;
  logic [OUT_BITS-1:0] coll;
  logic [OUT_BITS-1:0] coll_nxt;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic                valid_r;
  logic                err_r;
  logic                fb;
  logic                step;
  logic                xfer;

  assign fb        = ^(state & TAPS);
  assign state_nxt = {state[WIDTH-2:0], fb};
  assign xfer      = valid_r & out_ready;
  assign step      = enable & ~load_seed & (~valid_r | out_ready);
  assign seed_eff  = (seed == '0) ? RESET_SEED : seed;

  // A transfer in the same step starts the next word with just the new bit.
  always_comb begin
    coll_nxt = '0;
    cnt_nxt  = '0;
    if (xfer) begin
      coll_nxt = OUT_BITS'(state[WIDTH-1]);
      cnt_nxt  = CW'(1);
    end else begin
      coll_nxt = (coll << 1) | OUT_BITS'(state[WIDTH-1]);
      cnt_nxt  = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RESET_SEED;
      coll    <= '0;
      cnt     <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else if (load_seed) begin
      state   <= seed_eff;
      coll    <= '0;
      cnt     <= '0;
      valid_r <= 1'b0;
      err_r   <= (seed == '0);
    end else begin
      err_r <= 1'b0;
      if (step) begin
        state   <= state_nxt;
        coll    <= coll_nxt;
        cnt     <= cnt_nxt;
        valid_r <= (cnt_nxt == CW'(OUT_BITS));
      end else if (xfer) begin
        // Accepted while disabled: the stale word shifts out before the next one completes.
        valid_r <= 1'b0;
        cnt     <= '0;
      end
    end
  end

  assign out_data   = coll;
  assign out_valid  = valid_r;
  assign seed_err   = err_r;
  assign lfsr_state = state;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] pcnt;
  logic             hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start <= RESET_SEED;
      pcnt  <= '0;
      hit   <= 1'b0;
    end else if (load_seed) begin
      start <= seed_eff;
      pcnt  <= '0;
      hit   <= 1'b0;
    end else if (step) begin
      if (pcnt != '1) begin
        pcnt <= pcnt + WIDTH'(1);
      end
      hit <= (state_nxt == start);
    end else begin
      hit <= 1'b0;
    end
  end

  assign period_count = pcnt;
  assign period_hit   = hit;
`else
  assign period_count = '0;
  assign period_hit   = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream (4-bit LFSR, taps 1001, 4-bit words): vector table, corner sequences, randomized run vs. a bit-queue model.
module tb_lfsr_stream;

  localparam int         W  = 4;
  localparam int         OB = 4;
  localparam logic [3:0] TP = 4'b1001;
  localparam logic [3:0] RS = 4'b0001;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load_seed;
  logic [3:0] seed;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       seed_err;
  logic [3:0] lfsr_state;
  logic [3:0] period_count;
  logic       period_hit;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_stream #(
    .WIDTH(W), .TAPS(TP), .RESET_SEED(RS), .OUT_BITS(OB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_seed(load_seed), .seed(seed),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .seed_err(seed_err),
    .lfsr_state(lfsr_state), .period_count(period_count), .period_hit(period_hit)
  );

  typedef struct {
    logic       en;
    logic       ld;
    logic [3:0] sd;
    logic       rdy;
    logic [3:0] st;
    logic       vld;
    logic [3:0] dat;
    logic       err;
  } vec_t;

  vec_t tv[17];

  // Reference model: the LFSR as arithmetic on an integer, words as a queue of emitted bits.
  logic [3:0] m_state;
  logic [3:0] m_start;
  int         m_pcnt;
  logic       m_hit;
  logic       m_err;
  logic       m_valid;
  logic       m_bits[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    logic p;
    p = ($countones(s & TP) % 2) == 1;
    return {s[2:0], p};
  endfunction

  function automatic logic [3:0] m_word();
    logic [3:0] w;
    w = '0;
    foreach (m_bits[i]) w = (w << 1) | 4'(m_bits[i]);
    return w;
  endfunction

  task automatic model_reset();
    m_state = RS;
    m_start = RS;
    m_pcnt  = 0;
    m_hit   = 1'b0;
    m_err   = 1'b0;
    m_valid = 1'b0;
    m_bits.delete();
  endtask

  task automatic model_edge(input logic en, input logic ld, input logic [3:0] sd, input logic rdy);
    logic st;
    if (ld) begin
      m_state = (sd == 0) ? RS : sd;
      m_err   = (sd == 0);
      m_start = m_state;
      m_pcnt  = 0;
      m_hit   = 1'b0;
      m_valid = 1'b0;
      m_bits.delete();
    end else begin
      m_err = 1'b0;
      m_hit = 1'b0;
      st    = en && (!m_valid || rdy);
      if (m_valid && rdy) begin
        m_bits.delete();
        m_valid = 1'b0;
      end
      if (st) begin
        m_bits.push_back(m_state[3]);
        m_state = lfsr_next(m_state);
        m_pcnt  = (m_pcnt < 15) ? m_pcnt + 1 : 15;
        m_hit   = (m_state == m_start);
      end
      m_valid = (m_bits.size() == OB);
    end
  endtask

  task automatic apply(input logic en, input logic ld, input logic [3:0] sd, input logic rdy);
    enable    = en;
    load_seed = ld;
    seed      = sd;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    load_seed = 1'b0;
    seed      = '0;
    out_ready = 1'b0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    tv[0]  = '{1, 0, 4'h0, 1, 4'b0011, 0, 4'h0, 0};
    tv[1]  = '{1, 0, 4'h0, 1, 4'b0111, 0, 4'h0, 0};
    tv[2]  = '{1, 0, 4'h0, 1, 4'b1111, 0, 4'h0, 0};
    tv[3]  = '{1, 0, 4'h0, 1, 4'b1110, 1, 4'b0001, 0};
    tv[4]  = '{1, 0, 4'h0, 0, 4'b1110, 1, 4'b0001, 0};
    tv[5]  = '{1, 0, 4'h0, 0, 4'b1110, 1, 4'b0001, 0};
    tv[6]  = '{1, 0, 4'h0, 0, 4'b1110, 1, 4'b0001, 0};
    tv[7]  = '{1, 0, 4'h0, 0, 4'b1110, 1, 4'b0001, 0};
    tv[8]  = '{1, 0, 4'h0, 0, 4'b1110, 1, 4'b0001, 0};
    tv[9]  = '{1, 0, 4'h0, 1, 4'b1101, 0, 4'h0, 0};
    tv[10] = '{1, 0, 4'h0, 1, 4'b1010, 0, 4'h0, 0};
    tv[11] = '{1, 0, 4'h0, 1, 4'b0101, 0, 4'h0, 0};
    tv[12] = '{1, 0, 4'h0, 1, 4'b1011, 1, 4'b1110, 0};
    tv[13] = '{1, 1, 4'b1010, 1, 4'b1010, 0, 4'h0, 0};
    tv[14] = '{1, 1, 4'b0000, 1, 4'b0001, 0, 4'h0, 1};
    tv[15] = '{1, 0, 4'h0, 1, 4'b0011, 0, 4'h0, 0};
    tv[16] = '{0, 0, 4'h0, 1, 4'b0011, 0, 4'h0, 0};

    do_reset();
    chk("reset_state", 32'(lfsr_state), 32'(RS));
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_data", 32'(out_data), 0);
    chk("reset_err", 32'(seed_err), 0);
    chk("reset_pcnt", 32'(period_count), 0);
    chk("reset_phit", 32'(period_hit), 0);

    for (int i = 0; i < 17; i++) begin
      apply(tv[i].en, tv[i].ld, tv[i].sd, tv[i].rdy);
      chk($sformatf("vec%0d_state", i), 32'(lfsr_state), 32'(tv[i].st));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tv[i].vld));
      chk($sformatf("vec%0d_err", i), 32'(seed_err), 32'(tv[i].err));
      if (tv[i].vld) chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tv[i].dat));
    end

    // Period detection over two full cycles of the 15-state sequence.
    do_reset();
    for (int k = 1; k <= 31; k++) begin
      apply(1'b1, 1'b0, 4'h0, 1'b1);
`ifdef LFSR_PERIOD_CNT_EN
      chk($sformatf("period_cnt_%0d", k), 32'(period_count), (k < 15) ? k : 15);
      chk($sformatf("period_hit_%0d", k), 32'(period_hit), (k == 15 || k == 30) ? 1 : 0);
`else
      chk($sformatf("period_cnt_%0d", k), 32'(period_count), 0);
      chk($sformatf("period_hit_%0d", k), 32'(period_hit), 0);
`endif
    end

    // Reset mid-word, observed without a clock edge.
    do_reset();
    apply(1'b1, 1'b0, 4'h0, 1'b1);
    apply(1'b1, 1'b0, 4'h0, 1'b1);
    chk("midword_pre_state", 32'(lfsr_state), 32'(4'b0111));
    #2 reset = 1'b0;
    #1;
    chk("midword_async_state", 32'(lfsr_state), 32'(RS));
    chk("midword_async_valid", 32'(out_valid), 0);

    // Reset while a word is pending under backpressure.
    do_reset();
    for (int k = 0; k < 6; k++) apply(1'b1, 1'b0, 4'h0, 1'b0);
    chk("pending_valid", 32'(out_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("pending_async_valid", 32'(out_valid), 0);
    chk("pending_async_data", 32'(out_data), 0);

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic       en;
      logic       ld;
      logic [3:0] sd;
      logic       rdy;
      en  = ($urandom % 4) != 0;
      ld  = ($urandom % 40) == 0;
      sd  = (($urandom % 4) == 0) ? 4'h0 : 4'($urandom);
      rdy = ($urandom % 3) != 0;
      model_edge(en, ld, sd, rdy);
      apply(en, ld, sd, rdy);
      chk("rnd_state", 32'(lfsr_state), 32'(m_state));
      chk("rnd_valid", 32'(out_valid), 32'(m_valid));
      chk("rnd_err", 32'(seed_err), 32'(m_err));
      if (m_valid) chk("rnd_data", 32'(out_data), 32'(m_word()));
`ifdef LFSR_PERIOD_CNT_EN
      chk("rnd_pcnt", 32'(period_count), 32'(m_pcnt));
      chk("rnd_phit", 32'(period_hit), 32'(m_hit));
`else
      chk("rnd_pcnt", 32'(period_count), 0);
      chk("rnd_phit", 32'(period_hit), 0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
